dcache_data_array: RTL and testbench
====================================

Name: dcache_data_array

Overview:
- Parametrised successor to the single-way dcache data store: multi-way, byte-masked write, registered 1-cycle read with valid strobe.
- Self-clears all lines after reset via an internal init sequencer before accepting requests.
- Sits between the dcache controller (tag compare / way select) and the line-fill / write-back path.

Parameters:
- LINE_W, 256, data line width in bits; multiple of 8.
- SETS, 32, sets per way; power of 2, >= 2.
- WAYS, 2, number of ways; >= 1.
- Derived (localparam): IDX_W = clog2(SETS); WAY_W = max(1, clog2(WAYS)); BE_W = LINE_W/8.

Ports:
- clk_i, input, 1, clock; all state on rising edge.
- rst_i, input, 1, reset, asynchronous, active-high.
- req_i, input, 1, request strobe; accepted when req_i && ready_o.
- write_i, input, 1, 1 = write, 0 = read.
- way_i, input, WAY_W, target way.
- index_i, input, IDX_W, set index.
- data_i, input, LINE_W, write data.
- byte_en_i, input, BE_W, per-byte write enable; bit k covers data bits [8k+7:8k].
- ready_o, output, 1, high when able to accept a request.
- rvalid_o, output, 1, one-cycle pulse: data_o carries read result.
- data_o, output, LINE_W, read data; held between reads.
- init_done_o, output, 1, high once post-reset clear completes.

Behaviour:
- Reset (async assert): state = INIT, init counter = 0, ready_o = 0, rvalid_o = 0, data_o = 0, init_done_o = 0. Storage is not reset directly; the INIT sequence clears it.
- FSM, two states:
  - INIT: each cycle writes zero to set[counter] in all ways in parallel, then counter += 1. After writing set SETS-1, go to READY. Duration is exactly SETS cycles after reset deassertion. ready_o = 0 throughout; req_i is ignored, with no queueing.
  - READY: ready_o = 1 and init_done_o = 1. READY is terminal until the next reset.
- Write (accepted, write_i = 1): on the same edge, for each k with byte_en_i[k] = 1, byte k of line [way_i][index_i] takes data_i byte k. Other bytes are unchanged. byte_en_i = 0 is accepted as a no-op. rvalid_o stays 0.
- Read (accepted, write_i = 0): on the next edge, data_o = line [way_i][index_i] and rvalid_o = 1 for exactly one cycle. Latency is 1.
- Back-to-back: one request per cycle with no bubbles. A read issued the cycle after a write to the same line returns the post-write data. A read in cycle N and a write to the same line in cycle N+1 leaves data_o at the pre-write value.
- data_o holds its last read value when no read completes. It is not zeroed.
- way_i >= WAYS (only when WAYS is not a power of 2): writes are ignored; reads return data_o = 0 with rvalid_o = 1.
- Reset mid-operation (any state, including mid-INIT): immediate return to the reset values. Any in-flight read is dropped, so no rvalid_o pulse occurs. INIT restarts from set 0.

Optional Feature:
- Macro: DCACHE_DATA_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write and during INIT clear (parity of 0 = 0).
  - Adds output parity_err_o (1 bit). It pulses with rvalid_o when any read byte's stored parity mismatches. Reset value 0.
  - Adds input inject_err_i (1 bit): when set with an accepted write, the stored parity of every written byte is inverted. Test use only.
- Undefined: no parity storage and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Reset, release, hold req_i = 1: ready_o = 0 for exactly 32 cycles (SETS = 32), then 1. Read way 1 set 31 returns 0 with rvalid_o pulse one cycle after accept.
- Write way 0 idx 5 data = {32{8'hA5}}, byte_en = all 1s; next cycle read way 0 idx 5 -> data_o = all A5, rvalid_o = 1 for one cycle. Same read of way 1 idx 5 -> 0 (way isolation).
- Line all A5; write data = all 3C, byte_en = 32'h0000_00F0; read -> bytes 4..7 = 3C, all others A5. Write with byte_en = 0, then read -> line unchanged.
- Alternate write/read every cycle over idx 0..31 with pattern idx*8'h11: each read returns the prior write's value, with rvalid_o on every read cycle and no stalls.
- Assert rst_i while counter = 10 during INIT and again one cycle after a read accept: no rvalid_o; outputs return to 0; ready_o returns after exactly 32 cycles; previously written lines read 0.
- DCACHE_DATA_PARITY_EN: write with inject_err_i = 1, then read -> parity_err_o = 1 with rvalid_o. Rewrite normally, then read -> parity_err_o = 0.

Source files
------------

// File: rtl/dcache_data_array.sv
// Multi-way dcache data store: byte-masked writes, registered 1-cycle reads, self-clear after reset.
// Optional per-byte even parity with error injection when DCACHE_DATA_PARITY_EN is defined.
module dcache_data_array #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned SETS   = 32,
    parameter int unsigned WAYS   = 2,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned BE_W  = LINE_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef DCACHE_DATA_PARITY_EN
    input  logic              inject_err_i,
    output logic              parity_err_o,
`endif
    input  logic              req_i,
    input  logic              write_i,
    input  logic [WAY_W-1:0]  way_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic [BE_W-1:0]   byte_en_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [LINE_W-1:0] data_o,
    output logic              init_done_o
);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    localparam logic [WAY_W:0] WaysW = (WAY_W + 1)'(WAYS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               rvalid_q, rvalid_d;
    logic [LINE_W-1:0]  data_q, data_d;
    logic               accept, wr_en, rd_en, way_ok;
    logic [LINE_W-1:0]  rd_line;
    logic [LINE_W-1:0]  way_rd [WAYS];

    assign way_ok  = ({1'b0, way_i} < WaysW);
    assign accept  = req_i && ready_o;
    assign wr_en   = accept && write_i && way_ok;
    assign rd_en   = accept && !write_i;
    assign rd_line = way_ok ? way_rd[way_i] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                ready_o = 1'b1;
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        rvalid_d = rd_en;
        data_d   = data_q;
        if (rd_en) begin
            data_d = rd_line;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            data_q   <= data_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign data_o      = data_q;
    assign init_done_o = (state_q == StReady);

`ifdef DCACHE_DATA_PARITY_EN
    logic [BE_W-1:0] way_par_rd [WAYS];
    logic [BE_W-1:0] rd_par, rd_par_calc;
    logic            parity_err_q, parity_err_d;

    assign rd_par = way_ok ? way_par_rd[way_i] : '0;

    always_comb begin
        rd_par_calc = '0;
        for (int unsigned k = 0; k < BE_W; k++) begin
            rd_par_calc[k] = ^rd_line[8*k +: 8];
        end
        parity_err_d = rd_en && way_ok && (|(rd_par_calc ^ rd_par));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    // Storage has no reset; the INIT walk clears one set per cycle in every way.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_W-1:0] way_mem [SETS];
        logic              way_sel;

        assign way_sel   = wr_en && (way_i == WAY_W'(w));
        assign way_rd[w] = way_mem[index_i];

        always_ff @(posedge clk_i) begin
            if (state_q == StInit) begin
                way_mem[cnt_q] <= '0;
            end else if (way_sel) begin
                for (int unsigned k = 0; k < BE_W; k++) begin
                    if (byte_en_i[k]) begin
                        way_mem[index_i][8*k +: 8] <= data_i[8*k +: 8];
                    end
                end
            end
        end

`ifdef DCACHE_DATA_PARITY_EN
        logic [BE_W-1:0] way_par [SETS];

        assign way_par_rd[w] = way_par[index_i];

        always_ff @(posedge clk_i) begin
            if (state_q == StInit) begin
                way_par[cnt_q] <= '0;
            end else if (way_sel) begin
                for (int unsigned k = 0; k < BE_W; k++) begin
                    if (byte_en_i[k]) begin
                        way_par[index_i][k] <= (^data_i[8*k +: 8]) ^ inject_err_i;
                    end
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_dcache_data_array.sv
// Directed self-checking bench for dcache_data_array (default LINE_W=256, SETS=32, WAYS=2).
module tb_dcache_data_array;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned SETS   = 32;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WAY_W  = 1;
    localparam int unsigned BE_W   = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req_i = 1'b0;
    logic              write_i = 1'b0;
    logic [WAY_W-1:0]  way_i = '0;
    logic [IDX_W-1:0]  index_i = '0;
    logic [LINE_W-1:0] data_i = '0;
    logic [BE_W-1:0]   byte_en_i = '0;
    logic              ready_o, rvalid_o, init_done_o;
    logic [LINE_W-1:0] data_o;
`ifdef DCACHE_DATA_PARITY_EN
    logic              inject_err_i = 1'b0;
    logic              parity_err_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    dcache_data_array #(
        .LINE_W (LINE_W),
        .SETS   (SETS),
        .WAYS   (WAYS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef DCACHE_DATA_PARITY_EN
        .inject_err_i(inject_err_i),
        .parity_err_o(parity_err_o),
`endif
        .req_i       (req_i),
        .write_i     (write_i),
        .way_i       (way_i),
        .index_i     (index_i),
        .data_i      (data_i),
        .byte_en_i   (byte_en_i),
        .ready_o     (ready_o),
        .rvalid_o    (rvalid_o),
        .data_o      (data_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] i,
                      input logic [LINE_W-1:0] d, input logic [BE_W-1:0] be);
        req_i = 1'b1; write_i = 1'b1; way_i = w; index_i = i; data_i = d; byte_en_i = be;
        tick();
        req_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic rd(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] i);
        req_i = 1'b1; write_i = 1'b0; way_i = w; index_i = i;
        tick();
        req_i = 1'b0;
    endtask

    // Counts cycles until ready_o rises (bounded) and notes any rvalid_o seen meanwhile.
    task automatic wait_ready(output int n, output bit saw_rv);
        n = 0;
        saw_rv = 1'b0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
            if (rvalid_o && !ready_o) saw_rv = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        bit saw_rv;
        req_i = 1'b1; write_i = 1'b0; way_i = 1'b1; index_i = 5'd31;
        #1 rst_i = 1'b1;
        tick();
        tick();
        vectors++;
        if ({ready_o, rvalid_o, init_done_o} !== 3'b000 || data_o !== '0) begin
            miscompares++;
            $display("FAIL reset_vals: ready/rvalid/done=%b data_nz=%0d required 000/0",
                     {ready_o, rvalid_o, init_done_o}, (data_o != '0));
        end
        rst_i = 1'b0;
        wait_ready(n, saw_rv);
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL init_len: ready after %0d cycles, required 32", n);
        end
        vectors++;
        if (saw_rv || init_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL init_quiet: rvalid_during_init=%0d done=%b required 0/1",
                     saw_rv, init_done_o);
        end
        tick();
        req_i = 1'b0;
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== '0) begin
            miscompares++;
            $display("FAIL rd_w1_s31: rvalid=%b data_nz=%0d required 1/0", rvalid_o, (data_o != '0));
        end
        tick();
        vectors++;
        if (rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rvalid_pulse: rvalid=%b required 0", rvalid_o);
        end
    endtask

    task automatic test_write_read();
        logic [LINE_W-1:0] a5;
        a5 = {32{8'hA5}};
        wr(1'b0, 5'd5, a5, '1);
        vectors++;
        if (rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_no_rvalid: rvalid=%b required 0", rvalid_o);
        end
        rd(1'b0, 5'd5);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== a5) begin
            miscompares++;
            $display("FAIL rd_w0_s5: rvalid=%b data=%h required 1/%h", rvalid_o, data_o, a5);
        end
        tick();
        vectors++;
        if (rvalid_o !== 1'b0 || data_o !== a5) begin
            miscompares++;
            $display("FAIL hold: rvalid=%b data=%h required 0/%h", rvalid_o, data_o, a5);
        end
        rd(1'b1, 5'd5);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== '0) begin
            miscompares++;
            $display("FAIL way_iso: rvalid=%b data=%h required 1/0", rvalid_o, data_o);
        end
    endtask

    task automatic test_byte_mask();
        logic [LINE_W-1:0] exp;
        exp = {32{8'hA5}};
        exp[63:32] = {4{8'h3C}};
        wr(1'b0, 5'd5, {32{8'h3C}}, 32'h0000_00F0);
        rd(1'b0, 5'd5);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== exp) begin
            miscompares++;
            $display("FAIL byte_mask: data=%h required %h", data_o, exp);
        end
        wr(1'b0, 5'd5, {32{8'hFF}}, '0);
        rd(1'b0, 5'd5);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== exp) begin
            miscompares++;
            $display("FAIL be_zero: data=%h required %h", data_o, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [LINE_W-1:0] exp, old;
        int bad;
        bad = 0;
        req_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 17);
            exp = {32{b}};
            write_i = 1'b1; way_i = 1'b1; index_i = 5'(i); data_i = exp; byte_en_i = '1;
            tick();
            if (rvalid_o !== 1'b0 || ready_o !== 1'b1) bad++;
            write_i = 1'b0;
            tick();
            if (rvalid_o !== 1'b1 || data_o !== exp || ready_o !== 1'b1) bad++;
        end
        req_i = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_sweep: %0d bad cycles, required 0", bad);
        end
        // Read then write the same line: the read must see the pre-write value.
        old = {32{8'h33}};
        req_i = 1'b1; write_i = 1'b0; way_i = 1'b1; index_i = 5'd3;
        tick();
        write_i = 1'b1; data_i = {32{8'h5A}}; byte_en_i = '1;
        tick();
        req_i = 1'b0; write_i = 1'b0;
        vectors++;
        if (rvalid_o !== 1'b0 || data_o !== old) begin
            miscompares++;
            $display("FAIL rd_then_wr: rvalid=%b data=%h required 0/%h", rvalid_o, data_o, old);
        end
        rd(1'b1, 5'd3);
        vectors++;
        if (data_o !== {32{8'h5A}}) begin
            miscompares++;
            $display("FAIL rd_after_wr: data=%h required all 5a", data_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw_rv;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b1;
        #1;
        vectors++;
        if (ready_o !== 1'b0 || rvalid_o !== 1'b0 || data_o !== '0) begin
            miscompares++;
            $display("FAIL mid_init_rst: ready=%b rvalid=%b required 0/0", ready_o, rvalid_o);
        end
        tick();
        rst_i = 1'b0;
        wait_ready(n, saw_rv);
        vectors++;
        if (n != 32 || saw_rv) begin
            miscompares++;
            $display("FAIL mid_init_len: %0d cycles rv=%0d required 32/0", n, saw_rv);
        end
        wr(1'b0, 5'd7, {32{8'h77}}, '1);
        wr(1'b0, 5'd5, {32{8'hA5}}, '1);
        rd(1'b0, 5'd7);
        rst_i = 1'b1;
        #1;
        vectors++;
        if (rvalid_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rst: rvalid=%b data_nz=%0d ready=%b required 0/0/0",
                     rvalid_o, (data_o != '0), ready_o);
        end
        tick();
        rst_i = 1'b0;
        wait_ready(n, saw_rv);
        vectors++;
        if (n != 32 || saw_rv) begin
            miscompares++;
            $display("FAIL rd_rst_len: %0d cycles rv=%0d required 32/0", n, saw_rv);
        end
        rd(1'b0, 5'd7);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== '0) begin
            miscompares++;
            $display("FAIL cleared_s7: data=%h required 0", data_o);
        end
        rd(1'b0, 5'd5);
        vectors++;
        if (rvalid_o !== 1'b1 || data_o !== '0) begin
            miscompares++;
            $display("FAIL cleared_s5: data=%h required 0", data_o);
        end
    endtask

`ifdef DCACHE_DATA_PARITY_EN
    task automatic test_parity();
        inject_err_i = 1'b1;
        wr(1'b0, 5'd9, {32{8'h96}}, '1);
        inject_err_i = 1'b0;
        rd(1'b0, 5'd9);
        vectors++;
        if (rvalid_o !== 1'b1 || parity_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL par_inject: rvalid=%b perr=%b required 1/1", rvalid_o, parity_err_o);
        end
        tick();
        vectors++;
        if (parity_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL par_pulse: perr=%b required 0", parity_err_o);
        end
        wr(1'b0, 5'd9, {32{8'h96}}, '1);
        rd(1'b0, 5'd9);
        vectors++;
        if (rvalid_o !== 1'b1 || parity_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL par_clean: rvalid=%b perr=%b required 1/0", rvalid_o, parity_err_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_to_back();
        test_reset_mid();
`ifdef DCACHE_DATA_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
